// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared FPR CDB types and requester indices for the FP execution units.
package fpr_cdb_arbiter_pkg;
  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  localparam int N_FPR_CDB_REQ = 4;
  localparam int FPR_REQ_FMUL  = 0;
  localparam int FPR_REQ_FADD  = 1;
  localparam int FPR_REQ_FINV  = 2;
  localparam int FPR_REQ_LOAD  = 3;
endpackage

// File: rtl/fpr_cdb_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of mask at ptr, ptr+1, ... wrapping mod N.
module rr_pick #(
  parameter int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  logic [N-1:0]     rot;
  logic [PTR_W-1:0] first;

  // N is a power of two, so PTR_W-bit addition wraps exactly mod N.
  always_comb begin
    for (int i = 0; i < N; i++) rot[i] = mask[PTR_W'(i) + ptr];
  end

  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) first = PTR_W'(i);
  end

  assign any = |mask;
  assign idx = first + ptr;

  always_comb begin
    for (int i = 0; i < N; i++) onehot[i] = any && (idx == PTR_W'(i));
  end
endmodule

// File: rtl/fpr_cdb_arbiter.sv
// Round-robin arbiter with urgent tier sharing the FPR CDB; winner registered onto fpr_cdb.
module fpr_cdb_arbiter
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_FPR_CDB_REQ,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0]                req_urgent,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag,
  input  logic [N_REQ-1:0][31:0]          req_data,
  output logic [N_REQ-1:0]                req_ready,
  input  logic                            flush,
  output cdb_t                            fpr_cdb
);
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t             cdb_q, cdb_d;
  logic [N_REQ-1:0] urg, sel_mask, onehot;
  logic [PTR_W-1:0] win;
  logic             any, xfer;

  // Urgent requesters form a strict tier above the normal round-robin pool.
  always_comb begin
    urg      = req_valid & req_urgent;
    sel_mask = (|urg) ? urg : req_valid;
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .mask   (sel_mask),
    .ptr    (rr_ptr_q),
    .onehot (onehot),
    .idx    (win),
    .any    (any)
  );

  always_comb begin
    xfer      = any && !flush && reset;
    req_ready = xfer ? onehot : '0;
    rr_ptr_d  = rr_ptr_q;
    cdb_d     = cdb_q;
    cdb_d.valid = 1'b0;
    if (xfer) begin
      rr_ptr_d = win + PTR_W'(1);
      cdb_d    = '{valid: 1'b1, tag: req_tag[win], data: req_data[win]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign fpr_cdb = cdb_q;
endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Scoreboard bench for fpr_cdb_arbiter: grant checked same cycle, broadcast checked after the edge.
module tb_fpr_cdb_arbiter;
  import fpr_cdb_arbiter_pkg::*;
  localparam int N = 4;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic [N-1:0]                 req_valid = '0, req_urgent = '0, req_ready;
  logic [N-1:0][ROB_WIDTH-1:0]  req_tag = '0;
  logic [N-1:0][31:0]           req_data = '0;
  logic                         flush = 1'b0;
  cdb_t                         fpr_cdb;

  int   n_chk = 0, n_pass = 0;
  int   m_ptr = 0;
  cdb_t m_last = '0;
  cdb_t sb_q[$];
  int   seq = 0;

  always #5 clk = ~clk;

  fpr_cdb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_urgent(req_urgent),
    .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .flush(flush), .fpr_cdb(fpr_cdb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_payload();
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = ROB_WIDTH'(i * 7 + seq);
      req_data[i] = {8'(i + 1), 24'(seq * 13)};
    end
    seq++;
  endtask

  // Drive one cycle, check the combinational grant, then the registered broadcast.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] u, input logic f,
                       input bit fresh, output int granted);
    logic [N-1:0] msk, exp_rdy;
    cdb_t exp_cdb, got_cdb;
    @(negedge clk);
    if (fresh) set_payload();
    req_valid = v; req_urgent = u; flush = f;
    #1;
    msk = ((v & u) != 0) ? (v & u) : v;
    granted = -1;
    for (int k = 0; k < N; k++)
      if (granted < 0 && msk[(m_ptr + k) % N]) granted = (m_ptr + k) % N;
    if (f || !reset) granted = -1;
    exp_rdy = '0;
    if (granted >= 0) exp_rdy[granted] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_cdb = m_last;
    exp_cdb.valid = 1'b0;
    if (granted >= 0) begin
      exp_cdb = '{valid: 1'b1, tag: req_tag[granted], data: req_data[granted]};
      m_ptr = (granted + 1) % N;
    end
    m_last = exp_cdb;
    sb_q.push_back(exp_cdb);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else begin
      got_cdb = sb_q.pop_front();
      chk("cdb_valid", 64'(fpr_cdb.valid), 64'(got_cdb.valid));
      chk("cdb_tag",   64'(fpr_cdb.tag),   64'(got_cdb.tag));
      chk("cdb_data",  64'(fpr_cdb.data),  64'(got_cdb.data));
    end
  endtask

  initial begin
    int g;
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    // Reset held 3 cycles with requests pending: no grants, output cleared.
    req_valid = '1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(fpr_cdb.valid), 64'd0);
    end
    @(negedge clk); req_valid = '0; reset = 1'b1;
    repeat (2) cycle('0, '0, 1'b0, 1, g);
    chk("idle_grant", 64'(g), 64'(-1));

    // Single requester with fixed payload.
    @(negedge clk);
    req_tag[1] = ROB_WIDTH'(5); req_data[1] = 32'h3F800000;
    cycle(4'b0010, '0, 1'b0, 0, g);
    chk("single_grant", 64'(g), 64'd1);
    chk("single_tag", 64'(fpr_cdb.tag), 64'd5);
    chk("single_data", 64'(fpr_cdb.data), 64'h3F800000);

    // Move pointer to 0, then 8-cycle round-robin wrap.
    cycle(4'b0100, '0, 1'b0, 1, g);
    cycle(4'b1000, '0, 1'b0, 1, g);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, '0, 1'b0, 1, g);
      chk("rr_order", 64'(g), 64'(order[i]));
      chk("rr_duty", 64'(fpr_cdb.valid), 64'd1);
    end

    // Urgent override from ptr 0, then normal grant resumes at 0.
    cycle(4'b1011, 4'b1000, 1'b0, 1, g);
    chk("urgent_grant", 64'(g), 64'd3);
    cycle(4'b1011, '0, 1'b0, 1, g);
    chk("after_urgent", 64'(g), 64'd0);

    // Flush blocks the grant; pointer holds.
    cycle(4'b0001, '0, 1'b1, 1, g);
    chk("flush_valid", 64'(fpr_cdb.valid), 64'd0);
    cycle(4'b0001, '0, 1'b0, 0, g);
    chk("post_flush", 64'(g), 64'd0);

    // Async reset between edges during continuous requests.
    repeat (3) cycle(4'b1111, '0, 1'b0, 1, g);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 64'(fpr_cdb.valid), 64'd0);
    chk("async_data", 64'(fpr_cdb.data), 64'd0);
    chk("async_ready", 64'(req_ready), 64'd0);
    m_ptr = 0; m_last = '0;
    @(negedge clk); req_valid = '0;
    @(negedge clk); reset = 1'b1;
    cycle(4'b1111, '0, 1'b0, 1, g);
    chk("post_rst_grant", 64'(g), 64'd0);

    // Random mix of valid/urgent/flush.
    for (int i = 0; i < 60; i++)
      cycle(N'($urandom), ($urandom_range(3) == 0) ? N'($urandom) : '0,
            ($urandom_range(7) == 0), 1, g);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
